// File: rtl/umi_req_initiator.sv
// Single-outstanding UMI request initiator: turns one local read/write/posted
// command into a UMI request, waits for the matching response, reports completion.
module umi_req_initiator #(
    parameter int            CW      = 32,
    parameter int            AW      = 64,
    parameter int            DW      = 32,
    parameter logic [AW-1:0] SRCADDR = 64'h0,
    parameter int            TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    // local command
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic          cmd_posted,
    input  logic [2:0]    cmd_size,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    // local completion
    output logic          done_valid,
    input  logic          done_ready,
    output logic [1:0]    done_err,
    output logic [DW-1:0] done_rdata,
    // UMI request channel
    output logic          umi_req_valid,
    input  logic          umi_req_ready,
    output logic [CW-1:0] umi_req_cmd,
    output logic [AW-1:0] umi_req_dstaddr,
    output logic [AW-1:0] umi_req_srcaddr,
    output logic [DW-1:0] umi_req_data,
    // UMI response channel
    input  logic          umi_resp_valid,
    output logic          umi_resp_ready,
    input  logic [CW-1:0] umi_resp_cmd,
    input  logic [AW-1:0] umi_resp_dstaddr,
    input  logic [AW-1:0] umi_resp_srcaddr,
    input  logic [DW-1:0] umi_resp_data,
    // FSM state for observation: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE
    output logic [1:0]    dbg_state
);

    // Every channel uses valid/ready: a transfer happens on a cycle where both
    // are high; the sender holds its payload stable while valid is high and ready low.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int         LOG2B    = $clog2(DW / 8);
    localparam logic [2:0] MAX_SIZE = 3'(LOG2B);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_write;
    logic          r_posted;
    logic [2:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_err;
    logic [DW-1:0] r_rdata;
    logic [15:0]   r_cnt;

    logic          w_accept;
    logic          w_req_fire;
    logic          w_resp_fire;
    logic          w_done_fire;
    logic          w_size_bad;
    logic          w_timeout;
    logic [4:0]    w_exp_op;
    logic          w_op_ok;
    logic [DW-1:0] w_masked;
    logic [CW-1:0] w_req_cmd;
    logic          w_unused;

    assign w_accept    = cmd_valid & cmd_ready;
    assign w_req_fire  = umi_req_valid & umi_req_ready;
    assign w_resp_fire = umi_resp_valid & umi_resp_ready;
    assign w_done_fire = done_valid & done_ready;
    assign w_size_bad  = cmd_size > MAX_SIZE;
    assign w_timeout   = (r_cnt == TMO_LAST);
    assign w_exp_op    = r_write ? 5'h04 : 5'h02;
    assign w_op_ok     = (umi_resp_cmd[4:0] == w_exp_op);
    assign w_unused    = ^{umi_resp_dstaddr, umi_resp_srcaddr, umi_resp_cmd[CW-1:5]};

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < DW / 8; i++) begin
            if (i < (1 << r_size)) begin
                w_masked[i*8 +: 8] = umi_resp_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_req_cmd        = '0;
        w_req_cmd[4:0]   = !r_write ? 5'h01 : (r_posted ? 5'h05 : 5'h03);
        w_req_cmd[7:5]   = r_size;
        w_req_cmd[22]    = 1'b1;
        w_req_cmd[23]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_size_bad ? S_DONE : S_REQ;
            S_REQ:  if (w_req_fire) w_next = (r_write && r_posted) ? S_DONE : S_WAIT;
            S_WAIT: if (w_resp_fire || w_timeout) w_next = S_DONE;
            S_DONE: if (w_done_fire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_posted <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write  <= cmd_write;
                        r_posted <= cmd_posted;
                        r_size   <= cmd_size;
                        r_addr   <= cmd_addr;
                        r_wdata  <= cmd_wdata;
                        r_err    <= w_size_bad ? 2'b11 : 2'b00;
                        r_rdata  <= '0;
                    end
                end
                S_REQ: begin
                    if (w_req_fire) begin
                        r_cnt   <= '0;
                        r_err   <= 2'b00;
                        r_rdata <= '0;
                    end
                end
                S_WAIT: begin
                    // A response in the final counted cycle still wins over the timeout.
                    if (w_resp_fire) begin
                        r_err   <= w_op_ok ? 2'b00 : 2'b01;
                        r_rdata <= (w_op_ok && !r_write) ? w_masked : '0;
                    end else if (w_timeout) begin
                        r_err   <= 2'b10;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is held, independent of stale state.
    always_comb begin
        cmd_ready       = 1'b0;
        done_valid      = 1'b0;
        done_err        = '0;
        done_rdata      = '0;
        umi_req_valid   = 1'b0;
        umi_req_cmd     = '0;
        umi_req_dstaddr = '0;
        umi_req_srcaddr = '0;
        umi_req_data    = '0;
        umi_resp_ready  = 1'b0;
        dbg_state       = '0;
        if (!reset) begin
            umi_resp_ready = 1'b1;
            dbg_state      = r_state;
            case (r_state)
                S_IDLE: cmd_ready = 1'b1;
                S_REQ: begin
                    umi_req_valid   = 1'b1;
                    umi_req_cmd     = w_req_cmd;
                    umi_req_dstaddr = r_addr;
                    umi_req_srcaddr = SRCADDR;
                    umi_req_data    = r_write ? r_wdata : '0;
                end
                S_DONE: begin
                    done_valid = 1'b1;
                    done_err   = r_err;
                    done_rdata = r_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_umi_req_initiator.sv
// Directed bench for umi_req_initiator: the bench plays the UMI responder by hand
// and checks request fields, completion status/data and reset behaviour.
module tb_umi_req_initiator;

    localparam int CW      = 32;
    localparam int AW      = 64;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_posted;
    logic [2:0]    cmd_size;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          done_valid, done_ready;
    logic [1:0]    done_err;
    logic [DW-1:0] done_rdata;
    logic          umi_req_valid, umi_req_ready;
    logic [CW-1:0] umi_req_cmd;
    logic [AW-1:0] umi_req_dstaddr, umi_req_srcaddr;
    logic [DW-1:0] umi_req_data;
    logic          umi_resp_valid, umi_resp_ready;
    logic [CW-1:0] umi_resp_cmd;
    logic [AW-1:0] umi_resp_dstaddr, umi_resp_srcaddr;
    logic [DW-1:0] umi_resp_data;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW+1:0] exp_q[$];

    umi_req_initiator #(
        .CW(CW), .AW(AW), .DW(DW), .SRCADDR(64'h0), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_posted(cmd_posted), .cmd_size(cmd_size), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err),
        .done_rdata(done_rdata),
        .umi_req_valid(umi_req_valid), .umi_req_ready(umi_req_ready),
        .umi_req_cmd(umi_req_cmd), .umi_req_dstaddr(umi_req_dstaddr),
        .umi_req_srcaddr(umi_req_srcaddr), .umi_req_data(umi_req_data),
        .umi_resp_valid(umi_resp_valid), .umi_resp_ready(umi_resp_ready),
        .umi_resp_cmd(umi_resp_cmd), .umi_resp_dstaddr(umi_resp_dstaddr),
        .umi_resp_srcaddr(umi_resp_srcaddr), .umi_resp_data(umi_resp_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic pst, input logic [2:0] sz,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int budget = 20;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_posted = pst;
        cmd_size   = sz;
        cmd_addr   = addr;
        cmd_wdata  = wd;
        while (!cmd_ready && budget > 0) begin
            tick();
            budget--;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic respond(input logic [4:0] op, input logic [DW-1:0] data);
        umi_resp_valid = 1'b1;
        umi_resp_cmd   = {{(CW-5){1'b0}}, op};
        umi_resp_data  = data;
        chk("resp_ready", 64'(umi_resp_ready), 64'd1);
        tick();
        umi_resp_valid = 1'b0;
        umi_resp_cmd   = '0;
        umi_resp_data  = '0;
    endtask

    task automatic complete(input string tag);
        int budget = 40;
        logic [DW+1:0] exp;
        while (!done_valid && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_done_valid"}, 64'(done_valid), 64'd1);
        exp = 'x;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        chk({tag, "_err"}, 64'(done_err), 64'(exp[DW+1:DW]));
        chk({tag, "_rdata"}, 64'(done_rdata), 64'(exp[DW-1:0]));
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk({tag, "_done_drop"}, 64'(done_valid), 64'd0);
    endtask

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_posted = 0; cmd_size = '0;
        cmd_addr = '0; cmd_wdata = '0; done_ready = 0; umi_req_ready = 1;
        umi_resp_valid = 0; umi_resp_cmd = '0; umi_resp_dstaddr = '0;
        umi_resp_srcaddr = '0; umi_resp_data = '0;

        // reset
        repeat (3) tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_resp_ready", 64'(umi_resp_ready), 64'd0);
        chk("rst_req_valid", 64'(umi_req_valid), 64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_state", 64'(dbg_state), 64'd0);
        chk("idle_resp_ready", 64'(umi_resp_ready), 64'd1);

        // write 0x100 <= DEADBEEF
        exp_q.push_back({2'b00, 32'h0});
        send_cmd(1'b1, 1'b0, 3'd2, 64'h100, 32'hDEADBEEF);
        chk("wr_req_valid", 64'(umi_req_valid), 64'd1);
        chk("wr_req_cmd", 64'(umi_req_cmd), 64'h00C00043);
        chk("wr_dstaddr", umi_req_dstaddr, 64'h100);
        chk("wr_srcaddr", umi_req_srcaddr, 64'h0);
        chk("wr_data", 64'(umi_req_data), 64'hDEADBEEF);
        chk("wr_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        chk("wr_wait_state", 64'(dbg_state), 64'd2);
        respond(5'h04, 32'h0);
        complete("wr");

        // read-back at size 2, then size 0 and size 1
        exp_q.push_back({2'b00, 32'hDEADBEEF});
        send_cmd(1'b0, 1'b0, 3'd2, 64'h100, 32'h0);
        chk("rd2_req_cmd", 64'(umi_req_cmd), 64'h00C00041);
        chk("rd2_req_data", 64'(umi_req_data), 64'h0);
        tick();
        respond(5'h02, 32'hDEADBEEF);
        chk("rd2_done_latency", 64'(done_valid), 64'd1);
        complete("rd2");

        exp_q.push_back({2'b00, 32'h000000EF});
        send_cmd(1'b0, 1'b0, 3'd0, 64'h100, 32'h0);
        chk("rd0_req_cmd", 64'(umi_req_cmd), 64'h00C00001);
        tick();
        respond(5'h02, 32'hDEADBEEF);
        complete("rd0");

        exp_q.push_back({2'b00, 32'h00003344});
        send_cmd(1'b0, 1'b0, 3'd1, 64'h104, 32'h0);
        chk("rd1_req_cmd", 64'(umi_req_cmd), 64'h00C00021);
        tick();
        respond(5'h02, 32'h11223344);
        complete("rd1");

        // posted write, then a stray response
        exp_q.push_back({2'b00, 32'h0});
        send_cmd(1'b1, 1'b1, 3'd2, 64'h200, 32'h12345678);
        chk("ps_req_cmd", 64'(umi_req_cmd), 64'h00C00045);
        tick();
        chk("ps_done_latency", 64'(done_valid), 64'd1);
        complete("ps");
        respond(5'h04, 32'h0);
        chk("ps_stray_done", 64'(done_valid), 64'd0);
        chk("ps_stray_state", 64'(dbg_state), 64'd0);
        tick();
        chk("ps_stray_done2", 64'(done_valid), 64'd0);

        // timeout with silent responder
        exp_q.push_back({2'b10, 32'h0});
        send_cmd(1'b0, 1'b0, 3'd2, 64'h300, 32'h0);
        tick();
        repeat (15) tick();
        chk("to_last_wait_state", 64'(dbg_state), 64'd2);
        chk("to_last_wait_done", 64'(done_valid), 64'd0);
        tick();
        chk("to_done_at_16", 64'(done_valid), 64'd1);
        complete("to");
        respond(5'h02, 32'hAAAA5555);
        chk("late_done", 64'(done_valid), 64'd0);
        chk("late_state", 64'(dbg_state), 64'd0);
        exp_q.push_back({2'b00, 32'hCAFEF00D});
        send_cmd(1'b0, 1'b0, 3'd2, 64'h100, 32'h0);
        tick();
        respond(5'h02, 32'hCAFEF00D);
        complete("after_to");

        // response in the last counted cycle beats the timeout
        exp_q.push_back({2'b00, 32'h00000077});
        send_cmd(1'b0, 1'b0, 3'd2, 64'h100, 32'h0);
        tick();
        repeat (15) tick();
        chk("pri_state", 64'(dbg_state), 64'd2);
        respond(5'h02, 32'h00000077);
        chk("pri_done", 64'(done_valid), 64'd1);
        complete("pri");

        // bad response opcode
        exp_q.push_back({2'b01, 32'h0});
        send_cmd(1'b0, 1'b0, 3'd2, 64'h100, 32'h0);
        tick();
        respond(5'h04, 32'h55555555);
        complete("op");

        // illegal size
        exp_q.push_back({2'b11, 32'h0});
        send_cmd(1'b0, 1'b0, 3'd3, 64'h100, 32'h0);
        chk("sz_req_valid", 64'(umi_req_valid), 64'd0);
        chk("sz_state", 64'(dbg_state), 64'd3);
        complete("sz");
        chk("sz_req_valid_after", 64'(umi_req_valid), 64'd0);

        // request backpressure and completion backpressure
        umi_req_ready = 1'b0;
        exp_q.push_back({2'b00, 32'h0});
        send_cmd(1'b1, 1'b0, 3'd2, 64'h400, 32'hA5A5A5A5);
        cmd_valid = 1'b1;
        cmd_addr  = 64'h999;
        cmd_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", 64'(umi_req_valid), 64'd1);
            chk("bp_req_cmd", 64'(umi_req_cmd), 64'h00C00043);
            chk("bp_dstaddr", umi_req_dstaddr, 64'h400);
            chk("bp_data", 64'(umi_req_data), 64'hA5A5A5A5);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        cmd_valid = 1'b0;
        umi_req_ready = 1'b1;
        tick();
        respond(5'h04, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_done_valid", 64'(done_valid), 64'd1);
            chk("hold_done_err", 64'(done_err), 64'd0);
            tick();
        end
        complete("bp");

        // reset while waiting for a response
        send_cmd(1'b0, 1'b0, 3'd2, 64'h500, 32'h0);
        tick();
        chk("rw_state", 64'(dbg_state), 64'd2);
        reset = 1'b1;
        #1;
        chk("rw_rst_resp_ready", 64'(umi_resp_ready), 64'd0);
        chk("rw_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rw_rst_state", 64'(dbg_state), 64'd0);
        tick();
        chk("rw_after_state", 64'(dbg_state), 64'd0);
        chk("rw_after_done", 64'(done_valid), 64'd0);
        chk("rw_after_req_valid", 64'(umi_req_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("rw_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        respond(5'h02, 32'h00001234);
        chk("rw_stray_done", 64'(done_valid), 64'd0);
        exp_q.push_back({2'b00, 32'h0BADF00D});
        send_cmd(1'b0, 1'b0, 3'd2, 64'h100, 32'h0);
        tick();
        respond(5'h02, 32'h0BADF00D);
        complete("post_rst");

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
